// File: rtl/pwm_pkg.sv
// pwm_pkg: shared definitions for the PWM controller family.
//   PWM_N        default PWM counter / duty / phase width
//   PWM_H        default width of the periods-per-step hold field
//   ramp_state_e ramp sequencer state encoding
package pwm_pkg;

    localparam int unsigned PWM_N = 8;
    localparam int unsigned PWM_H = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } ramp_state_e;

endpackage

// File: rtl/pwm_period_timer.sv
// pwm_period_timer: free-running N-bit period counter kept in lock-step with
// the PWM counter (both leave reset together).
//   clock          system clock shared with the PWM
//   reset          synchronous, active-high
//   boundary_c     high while the counter sits at its last value (2^N-1)
//   period_sync_c  high while the counter is 0
module pwm_period_timer
    import pwm_pkg::*;
#(
    parameter int unsigned N = PWM_N
) (
    input  logic clock,
    input  logic reset,
    output logic boundary_c,
    output logic period_sync_c
);

    logic [N-1:0] cnt;

    // Natural wrap from 2^N-1 to 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + N'(1);
        end
    end

    assign boundary_c    = (cnt == {N{1'b1}});
    assign period_sync_c = (cnt == '0);

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// pwm_ramp_sequencer: steps a PWM channel's duty toward a commanded target,
// presenting new high_start/high_end only on period boundaries so the PWM
// latches a consistent pair during its cnt==0 cycle.
//   clock, reset              system clock; synchronous active-high reset
//   cmd_valid / cmd_ready     command handshake (ready only in IDLE)
//   cmd_target/step/hold/phase  ramp command fields (step/hold of 0 act as 1)
//   abort                     stop an active ramp, freezing the current duty
//   high_start / high_end     PWM dataHighStart / dataHighEnd
//   period_sync               pulse while the period counter is 0
//   busy                      ramp in progress
//   done                      one-cycle pulse when duty reaches target
module pwm_ramp_sequencer
    import pwm_pkg::*;
#(
    parameter int unsigned N = PWM_N,
    parameter int unsigned H = PWM_H
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [N-1:0] cmd_target,
    input  logic [N-1:0] cmd_step,
    input  logic [H-1:0] cmd_hold,
    input  logic [N-1:0] cmd_phase,
    input  logic         abort,
    output logic [N-1:0] high_start,
    output logic [N-1:0] high_end,
    output logic         period_sync,
    output logic         busy,
    output logic         done
);

    ramp_state_e  state;
    logic [N-1:0] duty;
    logic [N-1:0] target;
    logic [N-1:0] step;
    logic [N-1:0] phase;
    logic [H-1:0] hold_m1;
    logic [H-1:0] hold_cnt;

    logic         boundary_c;
    logic [N:0]   up_sum_c;
    logic [N-1:0] down_gap_c;
    logic [N-1:0] next_duty_c;

    pwm_period_timer #(.N(N)) u_timer (
        .clock         (clock),
        .reset         (reset),
        .boundary_c    (boundary_c),
        .period_sync_c (period_sync)
    );

    // Next duty: one step toward target, clamped so it never overshoots.
    always_comb begin
        up_sum_c    = {1'b0, duty} + {1'b0, step};
        down_gap_c  = duty - target;
        next_duty_c = duty;
        if (target > duty) begin
            next_duty_c = (up_sum_c > {1'b0, target}) ? target : up_sum_c[N-1:0];
        end else if (target < duty) begin
            next_duty_c = (step >= down_gap_c) ? target : duty - step;
        end
    end

    // Ramp FSM with registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            duty       <= '0;
            target     <= '0;
            step       <= '0;
            phase      <= '0;
            hold_m1    <= '0;
            hold_cnt   <= '0;
            high_start <= '0;
            high_end   <= '0;
            cmd_ready  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    if (cmd_valid && cmd_ready) begin
                        target    <= cmd_target;
                        step      <= (cmd_step == '0) ? N'(1) : cmd_step;
                        hold_m1   <= (cmd_hold == '0) ? '0 : cmd_hold - H'(1);
                        phase     <= cmd_phase;
                        // First update lands on the very next boundary;
                        // the hold spacing applies between updates.
                        hold_cnt  <= '0;
                        state     <= RAMP;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                RAMP: begin
                    if (abort) begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else if (boundary_c) begin
                        if (hold_cnt != '0) begin
                            hold_cnt <= hold_cnt - H'(1);
                        end else begin
                            duty       <= next_duty_c;
                            hold_cnt   <= hold_m1;
                            high_start <= phase;
                            high_end   <= phase + next_duty_c;
                            if (next_duty_c == target) begin
                                done      <= 1'b1;
                                state     <= IDLE;
                                cmd_ready <= 1'b1;
                                busy      <= 1'b0;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// tb_pwm_ramp_sequencer: directed ramp commands; expected output updates are
// queued at issue time and a negedge monitor pops and compares each time the
// outputs change or done pulses.
module tb_pwm_ramp_sequencer;

    localparam int unsigned N = 8;
    localparam int unsigned H = 8;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [N-1:0] cmd_target = '0;
    logic [N-1:0] cmd_step = '0;
    logic [H-1:0] cmd_hold = '0;
    logic [N-1:0] cmd_phase = '0;
    logic         abort = 1'b0;
    logic [N-1:0] high_start;
    logic [N-1:0] high_end;
    logic         period_sync;
    logic         busy;
    logic         done;

    pwm_ramp_sequencer #(.N(N), .H(H)) dut (
        .clock       (clock),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_target  (cmd_target),
        .cmd_step    (cmd_step),
        .cmd_hold    (cmd_hold),
        .cmd_phase   (cmd_phase),
        .abort       (abort),
        .high_start  (high_start),
        .high_end    (high_end),
        .period_sync (period_sync),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        int hs;
        int he;
        int dn;
        int gap;    // required clocks since previous event, 0 = don't care
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    bit   mon_quiet = 1'b1;
    int   prev_hs = 0;
    int   prev_he = 0;

    function automatic void check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: an event is any change of the output pair or a done pulse.
    always @(negedge clock) begin : monitor
        exp_t e;
        cyc++;
        if (mon_quiet) begin
            prev_hs  = int'(high_start);
            prev_he  = int'(high_end);
            last_cyc = cyc;
        end else if (int'(high_start) != prev_hs || int'(high_end) != prev_he || done) begin
            if (sb.size() == 0) begin
                check("unexpected_event", 1, 0);
            end else begin
                e = sb.pop_front();
                check("high_start", int'(high_start), e.hs);
                check("high_end", int'(high_end), e.he);
                check("done", int'(done), e.dn);
                check("update_on_sync", int'(period_sync), 1);
                if (e.gap != 0) check("update_gap", cyc - last_cyc, e.gap);
            end
            prev_hs  = int'(high_start);
            prev_he  = int'(high_end);
            last_cyc = cyc;
        end
    end

    task automatic push(input int hs, input int he, input int dn, input int gap);
        exp_t e;
        e.hs = hs; e.he = he; e.dn = dn; e.gap = gap;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        mon_quiet = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        cmd_valid = 1'b0;
        abort = 1'b0;
        @(negedge clock);
        check("rst_high_start", int'(high_start), 0);
        check("rst_high_end", int'(high_end), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_cmd_ready", int'(cmd_ready), 0);
        check("rst_period_sync", int'(period_sync), 1);
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_cmd_ready", int'(cmd_ready), 1);
        check("post_rst_period_sync", int'(period_sync), 0);
        sb.delete();
        mon_quiet = 1'b0;
    endtask

    task automatic send_cmd(input int t, input int s, input int h, input int p, input bit ab);
        int k;
        @(negedge clock);
        cmd_target = N'(t);
        cmd_step   = N'(s);
        cmd_hold   = H'(h);
        cmd_phase  = N'(p);
        cmd_valid  = 1'b1;
        abort      = ab;
        k = 0;
        while (!cmd_ready && k < 20) begin
            @(negedge clock);
            k++;
        end
        check("cmd_ready_at_issue", int'(cmd_ready), 1);
        @(negedge clock);
        cmd_valid = 1'b0;
        abort     = 1'b0;
        check("busy_after_accept", int'(busy), 1);
        check("cmd_ready_after_accept", int'(cmd_ready), 0);
    endtask

    task automatic wait_drain(input string name, input int max);
        int k;
        k = 0;
        while (sb.size() != 0 && k < max) begin
            @(negedge clock);
            k++;
        end
        check(name, sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        // Reset and idle behaviour, period_sync cadence.
        do_reset();
        repeat (254) @(negedge clock);
        check("sync_low_at_255", int'(period_sync), 0);
        @(negedge clock);
        check("sync_high_at_256", int'(period_sync), 1);
        check("idle_high_end", int'(high_end), 0);

        // Basic up-ramp.
        push(0, 2, 0, 0);
        push(0, 4, 1, 256);
        send_cmd(4, 2, 1, 0, 1'b0);
        wait_drain("drain_up_ramp", 700);
        @(negedge clock);
        check("busy_after_done", int'(busy), 0);
        check("ready_after_done", int'(cmd_ready), 1);

        // Clamp on up-ramp, then down-ramp with clamp.
        do_reset();
        push(0, 2, 0, 0);
        push(0, 4, 0, 256);
        push(0, 5, 1, 256);
        send_cmd(5, 2, 1, 0, 1'b0);
        wait_drain("drain_clamp_up", 1000);
        push(0, 2, 0, 0);
        push(0, 1, 1, 256);
        send_cmd(1, 3, 1, 0, 1'b0);
        wait_drain("drain_down", 800);

        // step=0 and hold=3.
        do_reset();
        push(0, 1, 0, 0);
        push(0, 2, 1, 768);
        send_cmd(2, 0, 3, 0, 1'b0);
        wait_drain("drain_hold3", 2000);

        // Phase wrap-around.
        do_reset();
        push(250, 4, 1, 0);
        send_cmd(10, 10, 1, 250, 1'b0);
        wait_drain("drain_phase", 600);

        // Abort after the first step.
        do_reset();
        push(0, 50, 0, 0);
        send_cmd(200, 50, 1, 0, 1'b0);
        wait_drain("drain_pre_abort", 600);
        @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_cmd_ready", int'(cmd_ready), 1);
        repeat (600) @(negedge clock);
        check("abort_high_end", int'(high_end), 50);
        check("abort_high_start", int'(high_start), 0);

        // Command with abort asserted in IDLE is accepted; then reset mid-ramp.
        push(0, 100, 0, 0);
        send_cmd(200, 50, 1, 0, 1'b1);
        wait_drain("drain_resume", 600);
        check("mid_ramp_busy", int'(busy), 1);
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
